// File: rtl/multi_proxy_controller.sv
// rtl/multi_proxy_controller.sv - per-column BISR controller mapping faulty PEs onto proxy slots
module multi_proxy_controller #(
  parameter int ROWS        = 4,
  parameter int COL_IDX     = 0,
  parameter int WORD_SIZE   = 16,
  parameter int NUM_PROXIES = 2,
  localparam int RW = $clog2(ROWS),
  localparam int SW = ($clog2(NUM_PROXIES + 1) > 1) ? $clog2(NUM_PROXIES + 1) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             proxy_map_done,
  input  logic [ROWS-1:0]                  STW_result_mat,
  input  logic                             weight_reload,
  input  logic [WORD_SIZE-1:0]             fpe_in_weight,
  input  logic [WORD_SIZE-1:0]             rcm_left_in,
  input  logic [NUM_PROXIES*WORD_SIZE-1:0] proxy_top_in,
  output logic [RW-1:0]                    fpe_idx_sel,
  output logic [ROWS-1:0]                  proxy_en,
  output logic [NUM_PROXIES-1:0]           load_proxy,
  output logic [WORD_SIZE-1:0]             fpe_weight,
  output logic [2:0]                       proxy_settings,
  output logic                             proxy_matmul,
  output logic [NUM_PROXIES*RW-1:0]        proxy_row_map,
  output logic [NUM_PROXIES-1:0]           proxy_slot_valid,
  output logic                             fault_detected,
  output logic                             unrepairable,
  output logic [WORD_SIZE-1:0]             proxy_left_in,
  output logic                             proxy_out_valid,
  output logic [NUM_PROXIES*WORD_SIZE-1:0] proxy_stalled_top_in
);

  if (NUM_PROXIES < 1 || NUM_PROXIES > ROWS || COL_IDX < 0) begin : g_bad_params
    $error("multi_proxy_controller: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD1,
    S_LOAD2,
    S_COMPUTE
  } state_t;

  state_t          state, state_n;
  logic [ROWS-1:0] fmask;
  logic [ROWS-1:0] assigned;
  logic [SW-1:0]   slot;
  logic [RW-1:0]   cur_idx;
  logic [ROWS-1:0] pending;
  logic [RW-1:0]   pidx;
  logic            trigger;
  logic            slot_full;

  assign pending        = fmask & ~assigned;
  assign trigger        = proxy_map_done && !(&STW_result_mat) && !stall;
  assign slot_full      = (slot == SW'(NUM_PROXIES));
  assign proxy_en       = assigned & fmask;
  assign fault_detected = |fmask;

  // Lowest pending row wins, so faults beyond the slot budget are the high rows.
  always_comb begin
    pidx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (pending[r]) pidx = RW'(r);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (trigger) state_n = S_SELECT;
      S_SELECT:  if (!stall) state_n = ((pending == '0) || slot_full) ? S_COMPUTE : S_LOAD1;
      S_LOAD1:   if (!stall) state_n = S_LOAD2;
      S_LOAD2:   if (!stall) state_n = S_SELECT;
      S_COMPUTE: state_n = S_COMPUTE;
      default:   state_n = S_IDLE;
    endcase
    if (weight_reload) state_n = S_IDLE;
  end

  // The array mux settles one cycle after fpe_idx_sel, so the weight is passed
  // through for both load cycles while the slot strobe is held.
  always_comb begin
    load_proxy     = '0;
    fpe_weight     = '0;
    proxy_settings = 3'b000;
    proxy_matmul   = 1'b0;
    case (state)
      S_LOAD1, S_LOAD2: begin
        for (int s = 0; s < NUM_PROXIES; s++) load_proxy[s] = (slot == SW'(s));
        fpe_weight     = fpe_in_weight;
        proxy_settings = 3'b001;
      end
      S_COMPUTE: begin
        proxy_matmul   = 1'b1;
        proxy_settings = 3'b110;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      fmask                <= '0;
      assigned             <= '0;
      slot                 <= '0;
      cur_idx              <= '0;
      fpe_idx_sel          <= '0;
      proxy_row_map        <= '0;
      proxy_slot_valid     <= '0;
      unrepairable         <= 1'b0;
      proxy_left_in        <= '0;
      proxy_out_valid      <= 1'b0;
      proxy_stalled_top_in <= '0;
    end else begin
      state <= state_n;

      if (!stall) begin
        proxy_left_in        <= rcm_left_in;
        proxy_out_valid      <= (proxy_left_in != '0) && (state == S_COMPUTE);
        proxy_stalled_top_in <= proxy_top_in;
      end

      if (weight_reload) begin
        fmask            <= '0;
        assigned         <= '0;
        slot             <= '0;
        proxy_slot_valid <= '0;
        proxy_row_map    <= '0;
        unrepairable     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (trigger) begin
              fmask    <= ~STW_result_mat;
              assigned <= '0;
              slot     <= '0;
            end
          end
          S_SELECT: begin
            if (!stall && (pending != '0)) begin
              if (slot_full) begin
                unrepairable <= 1'b1;
              end else begin
                fpe_idx_sel <= pidx;
                cur_idx     <= pidx;
              end
            end
          end
          S_LOAD2: begin
            if (!stall) begin
              assigned[cur_idx] <= 1'b1;
              for (int s = 0; s < NUM_PROXIES; s++) begin
                if (slot == SW'(s)) begin
                  proxy_row_map[s*RW +: RW] <= cur_idx;
                  proxy_slot_valid[s]       <= 1'b1;
                end
              end
              slot <= slot + SW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_proxy_controller.sv
// tb/tb_multi_proxy_controller.sv - scoreboard bench for multi_proxy_controller
module tb_multi_proxy_controller;
  localparam int ROWS = 4;
  localparam int WS   = 16;
  localparam int NP   = 2;
  localparam int RW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            proxy_map_done;
  logic [ROWS-1:0] STW_result_mat;
  logic            weight_reload;
  logic [WS-1:0]   fpe_in_weight;
  logic [WS-1:0]   rcm_left_in;
  logic [NP*WS-1:0] proxy_top_in;
  logic [RW-1:0]   fpe_idx_sel;
  logic [ROWS-1:0] proxy_en;
  logic [NP-1:0]   load_proxy;
  logic [WS-1:0]   fpe_weight;
  logic [2:0]      proxy_settings;
  logic            proxy_matmul;
  logic [NP*RW-1:0] proxy_row_map;
  logic [NP-1:0]   proxy_slot_valid;
  logic            fault_detected;
  logic            unrepairable;
  logic [WS-1:0]   proxy_left_in;
  logic            proxy_out_valid;
  logic [NP*WS-1:0] proxy_stalled_top_in;

  multi_proxy_controller #(.ROWS(ROWS), .COL_IDX(0), .WORD_SIZE(WS), .NUM_PROXIES(NP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .proxy_map_done(proxy_map_done),
    .STW_result_mat(STW_result_mat), .weight_reload(weight_reload),
    .fpe_in_weight(fpe_in_weight), .rcm_left_in(rcm_left_in), .proxy_top_in(proxy_top_in),
    .fpe_idx_sel(fpe_idx_sel), .proxy_en(proxy_en), .load_proxy(load_proxy),
    .fpe_weight(fpe_weight), .proxy_settings(proxy_settings), .proxy_matmul(proxy_matmul),
    .proxy_row_map(proxy_row_map), .proxy_slot_valid(proxy_slot_valid),
    .fault_detected(fault_detected), .unrepairable(unrepairable),
    .proxy_left_in(proxy_left_in), .proxy_out_valid(proxy_out_valid),
    .proxy_stalled_top_in(proxy_stalled_top_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [WS-1:0] wt(input int r);
    return 16'h1000 * WS'(r + 1) + 16'h00C3;
  endfunction

  // Array mux model: weight of the selected row.
  assign fpe_in_weight = wt(int'(fpe_idx_sel));

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int slot;
    int row;
    int lp;
  } exp_t;
  exp_t exp_q[$];

  int            lp_cnt = 0;
  logic [NP-1:0] prev_valid = '0;

  // Scoreboard: each load cycle and each newly valid slot is checked against the queue head.
  always @(negedge clk) begin
    logic [NP-1:0] new_bits;
    logic [NP-1:0] oh;
    new_bits = proxy_slot_valid & ~prev_valid;
    if (load_proxy != '0) begin
      lp_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexp_load", load_proxy, 0);
      end else begin
        oh = NP'(1) << exp_q[0].slot;
        check_eq("load_slot", load_proxy, oh);
        check_eq("load_weight", fpe_weight, wt(exp_q[0].row));
        check_eq("load_settings", proxy_settings, 3'b001);
      end
    end else if (new_bits != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_slot", new_bits, 0);
      end else begin
        oh = NP'(1) << exp_q[0].slot;
        check_eq("slot_bit", new_bits, oh);
        check_eq("row_map", proxy_row_map[exp_q[0].slot*RW +: RW], exp_q[0].row);
        check_eq("lp_cycles", lp_cnt, exp_q[0].lp);
        void'(exp_q.pop_front());
      end
      lp_cnt = 0;
    end
    prev_valid = proxy_slot_valid;
  end

  task automatic push_exp(input int s, input int r, input int lp);
    exp_t e;
    e.slot = s; e.row = r; e.lp = lp;
    exp_q.push_back(e);
  endtask

  task automatic wait_matmul(input int t0, input int exp_lat, input string tag);
    int n = 0;
    while (!proxy_matmul && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, cyc - t0, exp_lat);
    proxy_map_done = 1'b0;
  endtask

  task automatic do_reload(input string tag);
    weight_reload = 1'b1;
    @(negedge clk);
    weight_reload = 1'b0;
    check_eq({tag, "_valid"}, proxy_slot_valid, 0);
    check_eq({tag, "_matmul"}, proxy_matmul, 0);
    check_eq({tag, "_fault"}, fault_detected, 0);
    check_eq({tag, "_unrep"}, unrepairable, 0);
    check_eq({tag, "_map"}, proxy_row_map, 0);
    @(negedge clk);
  endtask

  int t0;

  initial begin
    rst = 1'b1; stall = 1'b0; proxy_map_done = 1'b0; STW_result_mat = '1;
    weight_reload = 1'b0; rcm_left_in = '0; proxy_top_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_load", load_proxy, 0);
    check_eq("rst_matmul", proxy_matmul, 0);
    check_eq("rst_settings", proxy_settings, 0);
    check_eq("rst_valid", proxy_slot_valid, 0);
    check_eq("rst_fault", fault_detected, 0);
    check_eq("rst_ov", proxy_out_valid, 0);
    check_eq("rst_idx", fpe_idx_sel, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single fault on row 1.
    STW_result_mat = 4'b1101; proxy_map_done = 1'b1; t0 = cyc;
    push_exp(0, 1, 2);
    wait_matmul(t0, 5, "t1_latency");
    check_eq("t1_idx", fpe_idx_sel, 1);
    check_eq("t1_en", proxy_en, 4'b0010);
    check_eq("t1_unrep", unrepairable, 0);
    check_eq("t1_settings", proxy_settings, 3'b110);
    check_eq("t1_weight0", fpe_weight, 0);
    do_reload("t1_reload");

    // Two faults, rows 0 and 3.
    STW_result_mat = 4'b0110; proxy_map_done = 1'b1; t0 = cyc;
    push_exp(0, 0, 2); push_exp(1, 3, 2);
    wait_matmul(t0, 8, "t2_latency");
    check_eq("t2_map", proxy_row_map, 4'b1100);
    check_eq("t2_en", proxy_en, 4'b1001);
    check_eq("t2_unrep", unrepairable, 0);
    do_reload("t2_reload");

    // Overflow: all four rows faulty, only rows 0 and 1 loaded.
    STW_result_mat = 4'b0000; proxy_map_done = 1'b1; t0 = cyc;
    push_exp(0, 0, 2); push_exp(1, 1, 2);
    wait_matmul(t0, 8, "t3_latency");
    check_eq("t3_unrep", unrepairable, 1);
    check_eq("t3_en", proxy_en, 4'b0011);
    check_eq("t3_map", proxy_row_map, 4'b0100);

    // Datapath while in COMPUTE.
    rcm_left_in = 16'h0005; proxy_top_in = {16'hBEEF, 16'h1234};
    @(negedge clk);
    check_eq("dp_left", proxy_left_in, 16'h0005);
    check_eq("dp_top", proxy_stalled_top_in, {16'hBEEF, 16'h1234});
    check_eq("dp_ov_early", proxy_out_valid, 0);
    @(negedge clk);
    check_eq("dp_ov", proxy_out_valid, 1);
    rcm_left_in = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check_eq("dp_ov_drop", proxy_out_valid, 0);
    stall = 1'b1; rcm_left_in = 16'h0007;
    @(negedge clk);
    check_eq("dp_stall_hold", proxy_left_in, 0);
    check_eq("dp_stall_matmul", proxy_matmul, 1);
    stall = 1'b0; rcm_left_in = 16'h0000;
    do_reload("t3_reload");

    // 3-cycle stall during LOAD1 for a row-2 fault.
    STW_result_mat = 4'b1011; proxy_map_done = 1'b1; t0 = cyc;
    push_exp(0, 2, 5);
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    wait_matmul(t0, 8, "t4_latency");
    check_eq("t4_en", proxy_en, 4'b0100);

    // Reload coinciding with a new trigger: reload wins.
    STW_result_mat = 4'b1110; proxy_map_done = 1'b1; weight_reload = 1'b1;
    @(negedge clk);
    weight_reload = 1'b0; proxy_map_done = 1'b0;
    check_eq("t5_collide_fault", fault_detected, 0);
    check_eq("t5_collide_valid", proxy_slot_valid, 0);
    @(negedge clk);
    check_eq("t5_collide_idle", proxy_settings, 0);

    // Reset while in LOAD2.
    STW_result_mat = 4'b0111; proxy_map_done = 1'b1;
    push_exp(0, 3, 2);
    repeat (3) @(negedge clk);
    check_eq("t5_in_load", load_proxy, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_load", load_proxy, 0);
    check_eq("t5_rst_weight", fpe_weight, 0);
    check_eq("t5_rst_settings", proxy_settings, 0);
    check_eq("t5_rst_fault", fault_detected, 0);
    check_eq("t5_rst_valid", proxy_slot_valid, 0);
    rst = 1'b0; proxy_map_done = 1'b0;
    exp_q.delete();
    lp_cnt = 0;
    @(negedge clk);

    // Fresh faults remap after reset.
    STW_result_mat = 4'b1010; proxy_map_done = 1'b1; t0 = cyc;
    push_exp(0, 0, 2); push_exp(1, 2, 2);
    wait_matmul(t0, 8, "t6_latency");
    check_eq("t6_map", proxy_row_map, 4'b1000);
    check_eq("t6_en", proxy_en, 4'b0101);

    check_eq("q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_proxy_controller.md
# multi_proxy_controller

Per-column BISR controller that repairs up to `NUM_PROXIES` faulty PEs in one systolic-array column by mapping each fault onto its own proxy PE slot. After STW completes, it snapshots the column's fault mask and serially selects each faulty row. It loads that row's stationary weight into the next free proxy slot, then switches all loaded proxies to matmul mode. It sits between the STW result collector and the array's proxy-PE muxes. It adds multi-fault coverage, an unrepairable flag, slot-to-row mapping outputs and a weight-reload return path.

## Interface
- `ROWS`, 4: PE rows in the column.
- `COL_IDX`, 0: column this instance serves; informational only.
- `WORD_SIZE`, 16: data/weight width.
- `NUM_PROXIES`, 2: proxy slots; 1 ≤ `NUM_PROXIES` ≤ `ROWS`.
- Derived: `RW = $clog2(ROWS)`, `SW = max(1,$clog2(NUM_PROXIES+1))`.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset; synchronous, active-high.
- `stall` in 1: global array stall.
- `proxy_map_done` in 1: proxy PE assignment is valid; enables mapping.
- `STW_result_mat` in `ROWS`: per-row STW pass bits; 1 = good, 0 = faulty.
- `weight_reload` in 1: single-cycle pulse; new weights are coming, so drop all mappings.
- `fpe_in_weight` in `WORD_SIZE`: stationary weight of the row on `fpe_idx_sel`; array mux, valid the cycle after `fpe_idx_sel` changes.
- `rcm_left_in` in `WORD_SIZE`: recompute left operand.
- `proxy_top_in` in `NUM_PROXIES*WORD_SIZE`: per-slot top input.
- `fpe_idx_sel` out `RW`: row whose weight is being fetched.
- `proxy_en` out `ROWS`: rows currently covered by a loaded proxy.
- `load_proxy` out `NUM_PROXIES`: one-hot slot being loaded.
- `fpe_weight` out `WORD_SIZE`: weight presented to the loading slot.
- `proxy_settings` out 3: `{stat_bit, fsm_out_select, fsm_op2_select}`.
- `proxy_matmul` out 1: proxies in compute mode.
- `proxy_row_map` out `NUM_PROXIES*RW`: slot s serves row `proxy_row_map[s*RW +: RW]`.
- `proxy_slot_valid` out `NUM_PROXIES`: slot s is loaded.
- `fault_detected` out 1: snapshot mask is non-zero.
- `unrepairable` out 1: the snapshot has more faults than `NUM_PROXIES`.
- `proxy_left_in` out `WORD_SIZE`: registered `rcm_left_in`.
- `proxy_out_valid` out 1: proxy output valid.
- `proxy_stalled_top_in` out `NUM_PROXIES*WORD_SIZE`: per-slot top input delayed one cycle.

## Operation
Internal registers:
- `fmask[ROWS]`: fault snapshot, `~STW_result_mat`.
- `assigned[ROWS]`: rows already given a proxy.
- `slot[SW]`: next free slot.
- `cur_idx[RW]`: row being loaded.

Derived signals:
- `pending = fmask & ~assigned`.
- `pidx` = lowest set index of `pending`; it is 0 when `pending` is 0.

States:
- **IDLE**
  - Outputs: `load_proxy=0`, `fpe_weight=0`, `proxy_settings=000`, `proxy_matmul=0`.
  - If `proxy_map_done && ~&STW_result_mat && !stall`: set `fmask <= ~STW_result_mat`, `assigned <= 0`, `slot <= 0`, then go to SELECT.
- **SELECT**
  - If `pending==0`, go to COMPUTE.
  - Else if `slot==NUM_PROXIES`, set `unrepairable <= 1` and go to COMPUTE.
  - Else set `fpe_idx_sel <= pidx`, `cur_idx <= pidx`, then go to LOAD1.
- **LOAD1**
  - Set `fpe_weight <= fpe_in_weight`, `load_proxy <= 1<<slot`, `proxy_settings <= 001`.
  - Go to LOAD2.
- **LOAD2**
  - Set `fpe_weight <= fpe_in_weight`; `proxy_settings` stays `001`.
  - Set `assigned[cur_idx] <= 1`, `proxy_row_map[slot] <= cur_idx`, `proxy_slot_valid[slot] <= 1`, `slot <= slot+1`.
  - Go to SELECT. On that transition `load_proxy <= 0`.
- **COMPUTE**
  - Outputs: `proxy_matmul=1`, `proxy_settings=110`, `fpe_weight=0`, `load_proxy=0`.
  - Remains here until `weight_reload`.

Combinational outputs:
- `proxy_en = assigned & fmask`.
- `fault_detected = |fmask`.

Override rules:
- `weight_reload`, from any state: go to IDLE and clear `fmask`, `assigned`, `slot`, `proxy_slot_valid`, `proxy_row_map` and `unrepairable`. It has priority over every transition except `rst`.
- `stall` freezes SELECT, LOAD1 and LOAD2: no state change, every register holds. COMPUTE ignores `stall`.

Datapath, updated only when `!stall`:
- `proxy_left_in <= rcm_left_in`.
- `proxy_out_valid <= (proxy_left_in != 0) && state==COMPUTE`.
- `proxy_stalled_top_in <= proxy_top_in`, all slots.

Faults beyond `NUM_PROXIES` are never loaded. The lowest-indexed rows win.

## Timing
- Reset: every output and register is 0 and the state is IDLE.
- Edge numbering: trigger seen at edge 0. Without stall:
  - SELECT at cycle 1.
  - Fault i (0-based) is in LOAD1 at cycle 2+3i and in LOAD2 at cycle 3+3i.
  - `proxy_matmul` rises at cycle 2+3k, where k = number of loaded faults.
- `load_proxy` is high for exactly 2 unstalled cycles per slot.
- `fpe_weight` is stable across both cycles when `fpe_in_weight` is stable.
- A `stall` of n cycles during mapping delays every later event by n cycles.
- `weight_reload` asserted in the same cycle as the IDLE trigger: reload wins, so the state stays IDLE.
- `rst` mid-load: the next cycle is IDLE with `load_proxy=0`.
- `proxy_out_valid` lags `rcm_left_in` by 2 unstalled cycles.

## Test plan
1. **Single fault:** ROWS=4, NP=2, `STW_result_mat=1101`, `proxy_map_done=1`.
   - `fpe_idx_sel=1`.
   - `load_proxy=01` for 2 cycles.
   - `proxy_row_map[0]=1`, `proxy_en=0010`.
   - `proxy_matmul=1` at cycle 5, `unrepairable=0`.
2. **Two faults:** `STW_result_mat=0110`.
   - Slot 0 maps to row 0, slot 1 maps to row 3.
   - `load_proxy` sequence 01,01,0,10,10.
   - `proxy_matmul` at cycle 8.
3. **Overflow:** `STW_result_mat=0000`, NP=2.
   - Rows 0 and 1 are loaded.
   - `unrepairable=1`, `proxy_en=0011`.
4. **Stall during LOAD1:** 3-cycle stall in LOAD1.
   - `load_proxy` and `fpe_weight` hold.
   - `proxy_matmul` is delayed by 3 cycles.
5. **Reload and reset:** `weight_reload` in COMPUTE.
   - Next cycle is IDLE with `proxy_slot_valid=0`.
   - Fresh faults then remap.
   - `rst` in LOAD2 clears all outputs.
6. **Datapath:** `rcm_left_in=0x0005` in COMPUTE.
   - `proxy_left_in=5` after 1 cycle.
   - `proxy_out_valid=1` after 2 cycles.
   - `rcm_left_in=0` deasserts `proxy_out_valid`.
